// File: rtl/dac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dac_pkg : shared constants and enums for the DAC waveform source. Rev 1.0 |
// +--------------------------------------------------------------------------+
package dac_pkg;

  localparam logic [3:0] DAC_CMD_WR_UPD = 4'b0011;
  localparam logic [3:0] DAC_ADDR_ALL   = 4'hF;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_DC  = 2'd3
  } wave_e;

  // The sample load happens on the IDLE-with-tick cycle, so no separate LOAD state is held.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2
  } dac_state_e;

endpackage
`default_nettype wire

// File: rtl/dac_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dac_tick_gen : one-cycle tick every CLK_DIV clocks while enabled. Rev 1.0 |
// +--------------------------------------------------------------------------+
module dac_tick_gen #(
  parameter int CLK_DIV = 5000
) (
  input  logic CLK50MHZ,
  input  logic RST,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == c_last);
  assign tick      = enable && w_at_last;

  always_ff @(posedge CLK50MHZ) begin
    if (RST || !enable) begin
      r_cnt <= '0;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_wave_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dac_wave_gen : phase-accumulator waveform source for the DAC SPI master.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module dac_wave_gen
  import dac_pkg::*;
#(
  parameter int          CLK_DIV  = 5000,
  parameter logic [11:0] DC_LEVEL = 12'h800
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic        enable,
  input  logic [1:0]  wave_sel,
  input  logic [11:0] step,
  input  logic [3:0]  channel,
  input  logic        clr_overrun,
  output logic [11:0] data,
  output logic [3:0]  address,
  output logic [3:0]  command,
  output logic        dactrig,
  input  logic        dacdone,
  output logic        busy,
  output logic        overrun
);

  dac_state_e  r_state;
  dac_state_e  w_next;
  logic        w_tick;
  logic        w_load;
  logic        w_drop;
  logic [11:0] r_phase;
  logic [11:0] r_data;
  logic [3:0]  r_address;
  logic [3:0]  r_command;
  logic        r_overrun;
  logic [11:0] w_sample;

  dac_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .CLK50MHZ (CLK50MHZ),
    .RST      (RST),
    .enable   (enable),
    .tick     (w_tick)
  );

  // A tick is only accepted while idle; anything else is a dropped sample.
  assign w_load = (r_state == ST_IDLE) && w_tick;
  assign w_drop = (r_state != ST_IDLE) && w_tick;

  always_comb begin
    w_sample = r_phase;
    case (wave_e'(wave_sel))
      WAVE_SAW: w_sample = r_phase;
      WAVE_TRI: w_sample = r_phase[11] ? ~{r_phase[10:0], 1'b0} : {r_phase[10:0], 1'b0};
      WAVE_SQR: w_sample = r_phase[11] ? 12'hFFF : 12'h000;
      WAVE_DC:  w_sample = DC_LEVEL;
      default:  w_sample = r_phase;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_tick)  w_next = ST_TRIG;
      ST_TRIG:              w_next = ST_WAIT;
      ST_WAIT: if (dacdone) w_next = ST_IDLE;
      default:              w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_phase   <= '0;
      r_data    <= '0;
      r_address <= '0;
      r_command <= '0;
    end else if (w_load) begin
      r_phase   <= r_phase + step;
      r_data    <= w_sample;
      r_address <= channel;
      r_command <= DAC_CMD_WR_UPD;
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign data    = r_data;
  assign address = r_address;
  assign command = r_command;
  assign dactrig = (r_state == ST_TRIG);
  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_wave_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dac_wave_gen : randomized bench against a transaction-level model.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_dac_wave_gen;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  wsel;
  logic [11:0] stp;
  logic [3:0]  chan;
  logic        clr;
  logic        dacdone;
  logic [11:0] data;
  logic [3:0]  address;
  logic [3:0]  command;
  logic        dactrig;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  dac_wave_gen #(
    .CLK_DIV  (CLK_DIV),
    .DC_LEVEL (12'h800)
  ) dut (
    .CLK50MHZ    (clk),
    .RST         (rst),
    .enable      (en),
    .wave_sel    (wsel),
    .step        (stp),
    .channel     (chan),
    .clr_overrun (clr),
    .data        (data),
    .address     (address),
    .command     (command),
    .dactrig     (dactrig),
    .dacdone     (dacdone),
    .busy        (busy),
    .overrun     (overrun)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Model state: a transfer is "in flight" from its accepted tick until the cycle dacdone is returned.
  int m_cnt, m_phase, m_data, m_addr, m_cmd, m_done_at, m_acc_cyc, cyc;
  bit m_busy, m_trig, m_ovr;
  int dly;
  bit spur;
  int trig_seen;

  function automatic int ref_sample(int p, int ws);
    case (ws)
      0:       return p;
      1:       return (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
      2:       return (p >= 2048) ? 4095 : 0;
      default: return 2048;
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    bit tk, real_done, dn;
    tk        = en && (m_cnt == CLK_DIV - 1);
    real_done = m_busy && (cyc == m_done_at);
    dn        = real_done;
    // Stray completions while idle or in the trigger cycle must be ignored.
    if (spur && !dn && (!m_busy || cyc == m_acc_cyc + 1) && ($urandom_range(7) == 0))
      dn = 1'b1;
    dacdone = dn;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_phase = 0; m_data = 0; m_addr = 0; m_cmd = 0;
      m_busy = 0; m_trig = 0; m_ovr = 0;
    end else begin
      bit set_ovr;
      set_ovr = 0;
      m_trig  = 0;
      if (tk) begin
        if (m_busy) begin
          set_ovr = 1;
        end else begin
          m_data    = ref_sample(m_phase, int'(wsel));
          m_addr    = int'(chan);
          m_cmd     = 3;
          m_phase   = (m_phase + int'(stp)) % 4096;
          m_trig    = 1;
          m_busy    = 1;
          m_acc_cyc = cyc;
          m_done_at = cyc + 1 + dly;
        end
      end
      if (real_done) m_busy = 0;
      if (set_ovr) m_ovr = 1;
      else if (clr) m_ovr = 0;
      m_cnt = !en ? 0 : ((m_cnt == CLK_DIV - 1) ? 0 : m_cnt + 1);
    end
    cyc++;
    #1;
    if (dactrig) trig_seen++;
    chk("dactrig", int'(dactrig), int'(m_trig));
    chk("busy",    int'(busy),    int'(m_busy));
    chk("data",    int'(data),    m_data);
    chk("address", int'(address), m_addr);
    chk("command", int'(command), m_cmd);
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_wait();
    for (int i = 0; i < 40 && !(m_busy && cyc > m_acc_cyc + 1); i++) cycle();
  endtask

  initial begin
    rst = 1; en = 0; wsel = 0; stp = 0; chan = 0; clr = 0; dacdone = 0;
    m_cnt = 0; m_phase = 0; m_data = 0; m_addr = 0; m_cmd = 0;
    m_busy = 0; m_trig = 0; m_ovr = 0; m_done_at = 0; m_acc_cyc = 0; cyc = 0;
    dly = 2; spur = 0; trig_seen = 0;

    // Reset state
    run(3);
    rst = 0;
    run(2);

    // Saw, step 0x100, dacdone two cycles after dactrig: wraps through F00 -> 000 with no overrun
    en = 1; wsel = 0; stp = 12'h100; chan = 0; dly = 2;
    trig_seen = 0;
    run(72);
    chk("saw_sample_count", trig_seen, 18);

    // Triangle then square at step 0x400
    rst = 1; run(1); rst = 0;
    wsel = 1; stp = 12'h400;
    run(22);
    wsel = 2;
    run(18);

    // Overrun with slow completion, then clear it
    dly = 10; wsel = 0; stp = 12'h010;
    run(40);
    chk("overrun_after_drops", int'(overrun), 1);
    dly = 2;
    run_until_wait();
    en = 0;
    run(20);
    clr = 1; run(1); clr = 0;
    run(3);
    chk("overrun_cleared", int'(overrun), 0);

    // Channel and waveform changed during WAIT only affect the next sample
    en = 1; dly = 3; spur = 1;
    run_until_wait();
    chan = 4'd5; wsel = 1;
    run(16);

    // Enable drops mid-transfer: transfer completes, then silence
    run_until_wait();
    en = 0;
    trig_seen = 0;
    run(25);
    chk("no_trig_while_disabled", trig_seen, 0);

    // Reset while in WAIT, then restart from phase 0
    en = 1; wsel = 0; stp = 12'h0F0;
    run_until_wait();
    rst = 1; run(1); rst = 0;
    chk("rst_data", int'(data), 0);
    chk("rst_busy", int'(busy), 0);
    run(12);

    // DC mode
    wsel = 3; stp = 12'h123; dly = 1;
    run(24);
    chk("dc_level", int'(data), 12'h800);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) wsel = 2'($urandom);
      if ($urandom_range(15) == 0) stp  = 12'($urandom);
      if ($urandom_range(15) == 0) chan = 4'($urandom);
      if ($urandom_range(40) == 0) en   = ~en;
      clr = ($urandom_range(15) == 0);
      rst = ($urandom_range(199) == 0);
      dly = $urandom_range(1, 8);
      cycle();
    end
    rst = 0; clr = 0;
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
